// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the Mini-SRC control sequencer: opcodes, bus/latch
// bit positions, FSM step encoding and the opcode class record.
package control_sequencer_pkg;

    localparam int OPCODE_W = 5;
    localparam int ALUOP_W  = 5;

    // Instruction opcodes (IR[31:27]); ALU operation codes reuse these values.
    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHR  = 5'b00111;
    localparam logic [4:0] OP_SHRA = 5'b01000;
    localparam logic [4:0] OP_SHL  = 5'b01001;
    localparam logic [4:0] OP_ROR  = 5'b01010;
    localparam logic [4:0] OP_ROL  = 5'b01011;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_ANDI = 5'b01101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_BRX  = 5'b10011;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_JAL  = 5'b10101;
    localparam logic [4:0] OP_IN   = 5'b10110;
    localparam logic [4:0] OP_OUT  = 5'b10111;
    localparam logic [4:0] OP_MFHI = 5'b11000;
    localparam logic [4:0] OP_MFLO = 5'b11001;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    // bus_src bit positions {PCout,MDRout,Zhighout,Zlowout,HIout,LOout,InPortout,Cout}
    localparam int BS_PC   = 7;
    localparam int BS_MDR  = 6;
    localparam int BS_ZHI  = 5;
    localparam int BS_ZLO  = 4;
    localparam int BS_HI   = 3;
    localparam int BS_LO   = 2;
    localparam int BS_INP  = 1;
    localparam int BS_C    = 0;

    // latch_en bit positions {PCin,IRin,MARin,MDRin,Yin,Zin,HIin,LOin,OutPortin,CONin,IncPC}
    localparam int LE_PC   = 10;
    localparam int LE_IR   = 9;
    localparam int LE_MAR  = 8;
    localparam int LE_MDR  = 7;
    localparam int LE_Y    = 6;
    localparam int LE_Z    = 5;
    localparam int LE_HI   = 4;
    localparam int LE_LO   = 3;
    localparam int LE_OUTP = 2;
    localparam int LE_CON  = 1;
    localparam int LE_INC  = 0;

    typedef enum logic [3:0] {
        ST_T0   = 4'd0,
        ST_T1   = 4'd1,
        ST_T2   = 4'd2,
        ST_T3   = 4'd3,
        ST_T4   = 4'd4,
        ST_T5   = 4'd5,
        ST_T6   = 4'd6,
        ST_T7   = 4'd7,
        ST_HALT = 4'd8
    } state_t;

    typedef struct packed {
        logic ralu;
        logic imm;
        logic muldiv;
        logic unary;
        logic ld;
        logic ldi;
        logic st;
        logic br;
        logic jr;
        logic jal;
        logic io;
        logic mfx;
        logic nop;
        logic halt;
        logic illegal;
    } op_class_t;

    // Final execute step of each instruction class.
    function automatic state_t last_step(input op_class_t c);
        state_t s;
        if (c.ralu || c.imm || c.ldi) begin
            s = ST_T5;
        end else if (c.muldiv || c.br) begin
            s = ST_T6;
        end else if (c.ld || c.st) begin
            s = ST_T7;
        end else if (c.unary || c.jal) begin
            s = ST_T4;
        end else begin
            s = ST_T3;
        end
        return s;
    endfunction

    // Successor of an execute step.
    function automatic state_t step_after(input state_t s);
        state_t n;
        case (s)
            ST_T3:   n = ST_T4;
            ST_T4:   n = ST_T5;
            ST_T5:   n = ST_T6;
            ST_T6:   n = ST_T7;
            default: n = ST_T0;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/control_sequencer_opcode_class_decoder.sv
// Maps the IR opcode field onto one-hot instruction classes for the sequencer.
module opcode_class_decoder
    import control_sequencer_pkg::*;
#(
    parameter int OPW = OPCODE_W
) (
    input  logic [OPW-1:0] opcode,
    output op_class_t      op_class
);

    // Classify the opcode; anything outside the defined set is illegal.
    always_comb begin
        op_class = '0;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:    op_class.ralu    = 1'b1;
            OP_ADDI, OP_ANDI, OP_ORI:           op_class.imm     = 1'b1;
            OP_MUL, OP_DIV:                     op_class.muldiv  = 1'b1;
            OP_NEG, OP_NOT:                     op_class.unary   = 1'b1;
            OP_LD:                              op_class.ld      = 1'b1;
            OP_LDI:                             op_class.ldi     = 1'b1;
            OP_ST:                              op_class.st      = 1'b1;
            OP_BRX:                             op_class.br      = 1'b1;
            OP_JR:                              op_class.jr      = 1'b1;
            OP_JAL:                             op_class.jal     = 1'b1;
            OP_IN, OP_OUT:                      op_class.io      = 1'b1;
            OP_MFHI, OP_MFLO:                   op_class.mfx     = 1'b1;
            OP_NOP:                             op_class.nop     = 1'b1;
            OP_HALT:                            op_class.halt    = 1'b1;
            default:                            op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/execute control sequencer for a Mini-SRC style datapath.
// Outputs are a decode of the step register and the IR opcode (valid from T3).
// Right after reset the sequencer sits one cycle in T0 with all controls quiet,
// so the reset state never drives the datapath.
module control_sequencer
    import control_sequencer_pkg::*;
#(
    parameter int OPW  = OPCODE_W,
    parameter int ALUW = ALUOP_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic [OPW-1:0]  opcode,
    input  logic            con_ff,
    input  logic            mem_ready,
    input  logic            stop,
    output logic            Gra,
    output logic            Grb,
    output logic            Grc,
    output logic            Rin,
    output logic            Rout,
    output logic            BAout,
    output logic [7:0]      bus_src,
    output logic [10:0]     latch_en,
    output logic [ALUW-1:0] alu_op,
    output logic            read,
    output logic            write,
    output logic            run,
    output logic            illegal
);

    state_t    state;
    state_t    next_state;
    state_t    end_state;
    logic      boot;
    logic      mem_wait;
    op_class_t cls;

    opcode_class_decoder #(.OPW(OPW)) u_decoder (
        .opcode   (opcode),
        .op_class (cls)
    );

    // Step register; boot marks the quiet cycle that follows reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_T0;
            boot  <= 1'b1;
        end else begin
            state <= next_state;
            boot  <= 1'b0;
        end
    end

    // Next step: fetch, class-dependent execute length, memory waits, stop/halt.
    always_comb begin
        end_state  = stop ? ST_HALT : ST_T0;
        mem_wait   = ((cls.ld && (state == ST_T6)) || (cls.st && (state == ST_T7))) && !mem_ready;
        next_state = state;
        if (boot) begin
            next_state = end_state;
        end else begin
            case (state)
                ST_T0: next_state = ST_T1;
                ST_T1: begin
                    if (mem_ready) begin
                        next_state = ST_T2;
                    end else begin
                        next_state = ST_T1;
                    end
                end
                ST_T2: next_state = ST_T3;
                ST_T3, ST_T4, ST_T5, ST_T6, ST_T7: begin
                    if ((state == ST_T3) && cls.halt) begin
                        next_state = ST_HALT;
                    end else if (mem_wait) begin
                        next_state = state;
                    end else if (state == last_step(cls)) begin
                        next_state = end_state;
                    end else begin
                        next_state = step_after(state);
                    end
                end
                ST_HALT: next_state = ST_HALT;
                default: next_state = ST_T0;
            endcase
        end
    end

    // Control decode for the current step and instruction class.
    always_comb begin
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        BAout    = 1'b0;
        bus_src  = 8'h00;
        latch_en = 11'h000;
        alu_op   = '0;
        read     = 1'b0;
        write    = 1'b0;
        illegal  = 1'b0;
        run      = (state != ST_HALT);
        if (boot) begin
            bus_src = 8'h00;
        end else begin
            case (state)
                ST_T0: begin
                    bus_src[BS_PC]   = 1'b1;
                    latch_en[LE_MAR] = 1'b1;
                    latch_en[LE_INC] = 1'b1;
                    latch_en[LE_Z]   = 1'b1;
                end
                ST_T1: begin
                    bus_src[BS_ZLO]  = 1'b1;
                    latch_en[LE_PC]  = 1'b1;
                    latch_en[LE_MDR] = 1'b1;
                    read             = 1'b1;
                end
                ST_T2: begin
                    bus_src[BS_MDR]  = 1'b1;
                    latch_en[LE_IR]  = 1'b1;
                end
                ST_T3: begin
                    if (cls.ralu || cls.imm) begin
                        Grb = 1'b1; Rout = 1'b1; latch_en[LE_Y] = 1'b1;
                    end else if (cls.muldiv) begin
                        Gra = 1'b1; Rout = 1'b1; latch_en[LE_Y] = 1'b1;
                    end else if (cls.unary) begin
                        Grb = 1'b1; Rout = 1'b1; latch_en[LE_Z] = 1'b1;
                        alu_op = ALUW'(opcode);
                    end else if (cls.ld || cls.ldi || cls.st) begin
                        Grb = 1'b1; BAout = 1'b1; latch_en[LE_Y] = 1'b1;
                    end else if (cls.br) begin
                        Gra = 1'b1; Rout = 1'b1; latch_en[LE_CON] = 1'b1;
                    end else if (cls.jr) begin
                        Gra = 1'b1; Rout = 1'b1; latch_en[LE_PC] = 1'b1;
                    end else if (cls.jal) begin
                        bus_src[BS_PC] = 1'b1; Grb = 1'b1; Rin = 1'b1;
                    end else if (cls.io) begin
                        if (opcode == OP_IN) begin
                            bus_src[BS_INP] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        end else begin
                            Gra = 1'b1; Rout = 1'b1; latch_en[LE_OUTP] = 1'b1;
                        end
                    end else if (cls.mfx) begin
                        if (opcode == OP_MFHI) begin
                            bus_src[BS_HI] = 1'b1;
                        end else begin
                            bus_src[BS_LO] = 1'b1;
                        end
                        Gra = 1'b1; Rin = 1'b1;
                    end else if (cls.illegal) begin
                        illegal = 1'b1;
                    end else begin
                        illegal = 1'b0;
                    end
                end
                ST_T4: begin
                    if (cls.ralu) begin
                        Grc = 1'b1; Rout = 1'b1; latch_en[LE_Z] = 1'b1;
                        alu_op = ALUW'(opcode);
                    end else if (cls.imm) begin
                        bus_src[BS_C] = 1'b1; latch_en[LE_Z] = 1'b1;
                        alu_op = ALUW'(opcode);
                    end else if (cls.muldiv) begin
                        Grb = 1'b1; Rout = 1'b1; latch_en[LE_Z] = 1'b1;
                        alu_op = ALUW'(opcode);
                    end else if (cls.unary) begin
                        bus_src[BS_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (cls.ld || cls.ldi || cls.st) begin
                        bus_src[BS_C] = 1'b1; latch_en[LE_Z] = 1'b1;
                        alu_op = ALUW'(OP_ADD);
                    end else if (cls.br) begin
                        bus_src[BS_PC] = 1'b1; latch_en[LE_Y] = 1'b1;
                    end else if (cls.jal) begin
                        Gra = 1'b1; Rout = 1'b1; latch_en[LE_PC] = 1'b1;
                    end else begin
                        illegal = 1'b0;
                    end
                end
                ST_T5: begin
                    if (cls.ralu || cls.imm) begin
                        // ALU op stays applied while Z low is written back.
                        bus_src[BS_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                        alu_op = ALUW'(opcode);
                    end else if (cls.ldi) begin
                        bus_src[BS_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (cls.ld || cls.st) begin
                        bus_src[BS_ZLO] = 1'b1; latch_en[LE_MAR] = 1'b1;
                    end else if (cls.muldiv) begin
                        bus_src[BS_ZLO] = 1'b1; latch_en[LE_LO] = 1'b1;
                    end else if (cls.br) begin
                        bus_src[BS_C] = 1'b1; latch_en[LE_Z] = 1'b1;
                        alu_op = ALUW'(OP_ADD);
                    end else begin
                        illegal = 1'b0;
                    end
                end
                ST_T6: begin
                    if (cls.muldiv) begin
                        bus_src[BS_ZHI] = 1'b1; latch_en[LE_HI] = 1'b1;
                    end else if (cls.ld) begin
                        read = 1'b1; latch_en[LE_MDR] = 1'b1;
                    end else if (cls.st) begin
                        Gra = 1'b1; Rout = 1'b1; latch_en[LE_MDR] = 1'b1;
                    end else if (cls.br) begin
                        bus_src[BS_ZLO] = 1'b1; latch_en[LE_PC] = con_ff;
                    end else begin
                        illegal = 1'b0;
                    end
                end
                ST_T7: begin
                    if (cls.ld) begin
                        bus_src[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end else if (cls.st) begin
                        write = 1'b1;
                    end else begin
                        illegal = 1'b0;
                    end
                end
                ST_HALT: begin
                    illegal = 1'b0;
                end
                default: begin
                    illegal = 1'b0;
                end
            endcase
        end
    end

    control_sequencer_checker u_checker (
        .clock    (clock),
        .reset    (reset),
        .bus_src  (bus_src),
        .Rout     (Rout),
        .BAout    (BAout)
    );

endmodule

// Bus contention guard: at most one driver on the shared bus each cycle.
module control_sequencer_checker (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] bus_src,
    input  logic       Rout,
    input  logic       BAout
);

    a_single_bus_driver: assert property (
        @(posedge clock) disable iff (reset)
        $countones({bus_src, Rout, BAout}) <= 1
    );

endmodule
